// File: rtl/sha_dit_pkg.sv
// Shared types and default widths for the sha1 data-independent-timing miter.
package sha_dit_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CMD_W  = 3;
  localparam int DEF_STAT_W = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int WARM_W     = 8;

  typedef enum logic [1:0] {
    S_WARMUP,
    S_ARMED,
    S_DIVERGED,
    S_VOID
  } mon_state_t;

  // True when the requested port widths are the ones the sha1 core really has.
  function automatic bit widths_match(int data_w, int cmd_w, int stat_w);
    return (data_w == DEF_DATA_W) && (cmd_w == DEF_CMD_W) && (stat_w == DEF_STAT_W);
  endfunction

endpackage

// File: rtl/dit_monitor.sv
// Divergence monitor: compares two copies' status (and optionally data) while
// their control agrees, and latches the first cycle where they differ.
module dit_monitor
  import sha_dit_pkg::*;
#(
  parameter int STAT_W     = DEF_STAT_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CMD_W      = DEF_CMD_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WARMUP_CYC = 0,
  parameter int CMP_DATA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd1,
  input  logic              cmd_w1,
  input  logic [CMD_W-1:0]  cmd2,
  input  logic              cmd_w2,
  input  logic [STAT_W-1:0] stat1,
  input  logic [STAT_W-1:0] stat2,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              armed,
  output logic              diverged,
  output logic              ctrl_void,
  output logic [CNT_W-1:0]  div_cycle,
  output logic [STAT_W-1:0] div_stat1,
  output logic [STAT_W-1:0] div_stat2
);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC);

  mon_state_t        state;
  logic [WARM_W-1:0] warm_cnt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic              ctrl_mismatch;
  logic              out_mismatch;

  assign ctrl_mismatch = {cmd1, cmd_w1} != {cmd2, cmd_w2};
  assign out_mismatch  = (stat1 != stat2) || ((CMP_DATA != 0) && (data1 != data2));

  // Monitor FSM with saturating cycle counter; control mismatch outranks output mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WARMUP;
      warm_cnt  <= '0;
      cyc_cnt   <= '0;
      armed     <= 1'b0;
      diverged  <= 1'b0;
      ctrl_void <= 1'b0;
      div_cycle <= '0;
      div_stat1 <= '0;
      div_stat2 <= '0;
    end else begin
      if (cyc_cnt != {CNT_W{1'b1}}) cyc_cnt <= cyc_cnt + 1'b1;
      case (state)
        S_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state <= S_ARMED;
            armed <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_ARMED: begin
          if (ctrl_mismatch) begin
            state     <= S_VOID;
            armed     <= 1'b0;
            ctrl_void <= 1'b1;
          end else if (out_mismatch) begin
            state     <= S_DIVERGED;
            armed     <= 1'b0;
            diverged  <= 1'b1;
            div_cycle <= cyc_cnt;
            div_stat1 <= stat1;
            div_stat2 <= stat2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sha1.sv
// Single-block SHA-1 core: 16 words are shifted in, 80 rounds run in fixed
// time, then the 5 digest words are read out by rotation through text_o.
// cmd_i: 001 load word, 010 start, 100 rotate digest. cmd_o = {busy, done, load_cnt}.
module sha1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] text_i,
  output logic [31:0] text_o,
  input  logic [2:0]  cmd_i,
  input  logic        cmd_w_i,
  output logic [3:0]  cmd_o
);

  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b100;

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;

  logic [31:0] w [16];
  logic [31:0] h [5];
  logic [31:0] a, b, c, d, e;
  logic [6:0]  round;
  logic        busy;
  logic        done;
  logic [1:0]  load_cnt;
  logic [31:0] f_val, k_val, t_val, w_mix;

  // Round function, constant and message-schedule expansion for the current round.
  always_comb begin
    f_val = b ^ c ^ d;
    k_val = 32'hCA62C1D6;
    if (round < 7'd20) begin
      f_val = (b & c) | (~b & d);
      k_val = 32'h5A827999;
    end else if (round < 7'd40) begin
      f_val = b ^ c ^ d;
      k_val = 32'h6ED9EBA1;
    end else if (round < 7'd60) begin
      f_val = (b & c) | (b & d) | (c & d);
      k_val = 32'h8F1BBCDC;
    end
    t_val = {a[26:0], a[31:27]} + f_val + e + k_val + w[0];
    w_mix = w[13] ^ w[8] ^ w[2] ^ w[0];
  end

  // Command handling and the round engine; commands are ignored while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      round    <= '0;
      load_cnt <= '0;
      a <= '0; b <= '0; c <= '0; d <= '0; e <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 5; i++)  h[i] <= '0;
    end else if (busy) begin
      a <= t_val;
      b <= a;
      c <= {b[1:0], b[31:2]};
      d <= c;
      e <= d;
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= {w_mix[30:0], w_mix[31]};
      if (round == 7'd79) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        round <= '0;
        h[0]  <= IV0 + t_val;
        h[1]  <= IV1 + a;
        h[2]  <= IV2 + {b[1:0], b[31:2]};
        h[3]  <= IV3 + c;
        h[4]  <= IV4 + d;
      end else begin
        round <= round + 7'd1;
      end
    end else if (cmd_w_i) begin
      case (cmd_i)
        CMD_LOAD: begin
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15]    <= text_i;
          load_cnt <= load_cnt + 2'd1;
          done     <= 1'b0;
        end
        CMD_START: begin
          busy  <= 1'b1;
          done  <= 1'b0;
          round <= '0;
          a <= IV0; b <= IV1; c <= IV2; d <= IV3; e <= IV4;
        end
        CMD_READ: begin
          for (int i = 0; i < 4; i++) h[i] <= h[i+1];
          h[4] <= h[0];
        end
        default: ;
      endcase
    end
  end

  assign text_o = h[0];
  assign cmd_o  = {busy, done, load_cnt};

endmodule

// File: rtl/sha_dit_miter.sv
// Miter of two sha1 cores sharing clock/reset, with optional shared control
// and a divergence monitor watching their status and data outputs.
module sha_dit_miter
  import sha_dit_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int STAT_W      = DEF_STAT_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WARMUP_CYC  = 0,
  parameter int SHARED_CTRL = 1,
  parameter int CMP_DATA    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] text_i1,
  input  logic [DATA_W-1:0] text_i2,
  input  logic [CMD_W-1:0]  cmd_i1,
  input  logic [CMD_W-1:0]  cmd_i2,
  input  logic              cmd_w_i1,
  input  logic              cmd_w_i2,
  output logic [DATA_W-1:0] text_o1,
  output logic [DATA_W-1:0] text_o2,
  output logic [STAT_W-1:0] cmd_o1,
  output logic [STAT_W-1:0] cmd_o2,
  output logic              armed,
  output logic              diverged,
  output logic              ctrl_void,
  output logic [CNT_W-1:0]  div_cycle,
  output logic [STAT_W-1:0] div_stat1,
  output logic [STAT_W-1:0] div_stat2
);

  localparam bit WIDTHS_OK = widths_match(DATA_W, CMD_W, STAT_W);

  if (!WIDTHS_OK) begin : g_width_check
    $error("sha_dit_miter widths must match the sha1 core (32/3/4)");
  end

  logic [CMD_W-1:0] cmd_c2;
  logic             cmd_w_c2;

  // With shared control copy 2 follows copy 1, so the monitor never sees a control mismatch.
  assign cmd_c2   = (SHARED_CTRL != 0) ? cmd_i1   : cmd_i2;
  assign cmd_w_c2 = (SHARED_CTRL != 0) ? cmd_w_i1 : cmd_w_i2;

  sha1 u_core1 (
    .clk     (clk),
    .rst     (rst),
    .text_i  (text_i1),
    .text_o  (text_o1),
    .cmd_i   (cmd_i1),
    .cmd_w_i (cmd_w_i1),
    .cmd_o   (cmd_o1)
  );

  sha1 u_core2 (
    .clk     (clk),
    .rst     (rst),
    .text_i  (text_i2),
    .text_o  (text_o2),
    .cmd_i   (cmd_c2),
    .cmd_w_i (cmd_w_c2),
    .cmd_o   (cmd_o2)
  );

  dit_monitor #(
    .STAT_W     (STAT_W),
    .DATA_W     (DATA_W),
    .CMD_W      (CMD_W),
    .CNT_W      (CNT_W),
    .WARMUP_CYC (WARMUP_CYC),
    .CMP_DATA   (CMP_DATA)
  ) u_monitor (
    .clk       (clk),
    .rst       (rst),
    .cmd1      (cmd_i1),
    .cmd_w1    (cmd_w_i1),
    .cmd2      (cmd_c2),
    .cmd_w2    (cmd_w_c2),
    .stat1     (cmd_o1),
    .stat2     (cmd_o2),
    .data1     (text_o1),
    .data2     (text_o2),
    .armed     (armed),
    .diverged  (diverged),
    .ctrl_void (ctrl_void),
    .div_cycle (div_cycle),
    .div_stat1 (div_stat1),
    .div_stat2 (div_stat2)
  );

endmodule
